// File: rtl/usb_defs.sv
// Shared definitions for the full-speed USB low-level transmitter:
// line states as {dp,dn}, FSM state encodings and the SYNC pattern.
package usb_defs;

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

    // Sent LSB first: seven raw 0s then a raw 1, i.e. KJKJKJKK on the line.
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    // Bits of a single run that pass without a stuffed 0.
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    // Raw 1s sent in place of a missing byte when the underrun error is built in.
    localparam logic [2:0] UNDERRUN_LAST_BIT = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_DATA     = 3'd2,
        ST_EOP_SE0  = 3'd3,
        ST_EOP_J    = 3'd4,
        ST_UNDERRUN = 3'd5
    } tx_state_e;

    function automatic logic [1:0] level_to_line(input logic level_k);
        return level_k ? LS_K : LS_J;
    endfunction

endpackage

// File: rtl/usb_tx_nrzi_stuff.sv
// NRZI encoder with bit-stuff tracking: holds the line level and the count
// of consecutive raw 1s, and asks the byte shifter to pause for a stuffed 0.
module usb_tx_nrzi_stuff
    import usb_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_stb_i,
    input  logic       raw_bit_i,
    input  logic       restart_i,
    output logic [1:0] line_o,
    output logic       stuff_req_o
);

    logic [2:0] ones_q, ones_d;
    logic       level_q, level_d;
    logic [2:0] ones_base;
    logic       level_base;

    // A restart begins from J with a clear counter even when it coincides
    // with the first bit strobe of the packet.
    assign ones_base  = restart_i ? 3'd0 : ones_q;
    assign level_base = restart_i ? 1'b0 : level_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ones_d  = ones_base;
        level_d = level_base;
        if (bit_stb_i) begin
            if (ones_base == STUFF_LIMIT) begin
                ones_d  = 3'd0;
                level_d = ~level_base;
            end else if (raw_bit_i) begin
                ones_d  = ones_base + 3'd1;
            end else begin
                ones_d  = 3'd0;
                level_d = ~level_base;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q  <= 3'd0;
            level_q <= 1'b0;
        end else begin
            ones_q  <= ones_d;
            level_q <= level_d;
        end
    end

    assign line_o      = level_to_line(level_q);
    assign stuff_req_o = (ones_q == STUFF_LIMIT);

endmodule

// File: rtl/usb_tx_ll.sv
// Full-speed USB low-level transmitter: SYNC, NRZI data with bit stuffing, EOP.
// Build option USB_TX_UNDERRUN_EN: a starved fetch sends a deliberate stuff error.
module usb_tx_ll
    import usb_defs::*;
#(
    parameter int BIT_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       phy_tx_dp,
    output logic       phy_tx_dn,
    output logic       phy_tx_en,
    output logic       tx_busy,
`ifdef USB_TX_UNDERRUN_EN
    output logic       tx_underrun,
`endif
    output logic       tx_done
);

    localparam int DIV_W = $clog2(BIT_DIV);

    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             last_q, last_d;
    logic             done_q, done_d;

    logic             strobe;
    logic [2:0]       next_idx;
    logic             bit_stb;
    logic             raw_bit;
    logic             restart;
    logic             fetch;
    logic [1:0]       nrzi_line;
    logic             stuff_req;

`ifdef USB_TX_UNDERRUN_EN
    logic             underrun_q, underrun_d;
    logic             underrun_pulse_q;
`endif

    // Last clock of the bit currently on the pads.
    assign strobe   = (div_cnt_q == DIV_W'(BIT_DIV - 1));
    assign next_idx = bit_cnt_q + 3'd1;

    usb_tx_nrzi_stuff u_nrzi_stuff (
        .clk         (clk),
        .rst         (rst),
        .bit_stb_i   (bit_stb),
        .raw_bit_i   (raw_bit),
        .restart_i   (restart),
        .line_o      (nrzi_line),
        .stuff_req_o (stuff_req)
    );

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        last_d    = last_q;
        done_d    = 1'b0;
        bit_stb   = 1'b0;
        raw_bit   = 1'b1;
        restart   = 1'b0;
        fetch     = 1'b0;
`ifdef USB_TX_UNDERRUN_EN
        underrun_d = underrun_q;
`endif

        if (state_q != ST_IDLE) begin
            div_cnt_d = strobe ? '0 : div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d   = ST_SYNC;
                    div_cnt_d = '0;
                    bit_cnt_d = 3'd0;
                    shift_d   = SYNC_PATTERN;
                    last_d    = 1'b0;
                    restart   = 1'b1;
                    bit_stb   = 1'b1;
                    raw_bit   = SYNC_PATTERN[0];
`ifdef USB_TX_UNDERRUN_EN
                    underrun_d = 1'b0;
`endif
                end
            end

            ST_SYNC, ST_DATA: begin
                if (strobe) begin
                    if (stuff_req) begin
                        // Stuffed 0 goes out; the shifter keeps its position.
                        bit_stb = 1'b1;
                        raw_bit = 1'b0;
                    end else if (bit_cnt_q != 3'd7) begin
                        bit_cnt_d = next_idx;
                        bit_stb   = 1'b1;
                        raw_bit   = shift_q[next_idx];
                    end else if (state_q == ST_DATA && last_q) begin
                        state_d   = ST_EOP_SE0;
                        bit_cnt_d = 3'd0;
                    end else begin
                        fetch = 1'b1;
                        if (in_valid) begin
                            state_d   = ST_DATA;
                            shift_d   = in_data;
                            last_d    = in_last;
                            bit_cnt_d = 3'd0;
                            bit_stb   = 1'b1;
                            raw_bit   = in_data[0];
                        end else begin
`ifdef USB_TX_UNDERRUN_EN
                            state_d    = ST_UNDERRUN;
                            underrun_d = 1'b1;
`else
                            state_d    = ST_EOP_SE0;
`endif
                            bit_cnt_d = 3'd0;
                        end
                    end
                end
            end

            // Raw 1s hold the NRZI level, so the encoder is simply not strobed.
            ST_UNDERRUN: begin
                if (strobe) begin
                    if (bit_cnt_q == UNDERRUN_LAST_BIT) begin
                        state_d   = ST_EOP_SE0;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = next_idx;
                    end
                end
            end

            ST_EOP_SE0: begin
                if (strobe) begin
                    if (bit_cnt_q[0]) begin
                        state_d   = ST_EOP_J;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = next_idx;
                    end
                end
            end

            ST_EOP_J: begin
                if (strobe) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

`ifdef USB_TX_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q       <= 1'b0;
            underrun_pulse_q <= 1'b0;
        end else begin
            underrun_q       <= underrun_d;
            underrun_pulse_q <= done_d & underrun_q;
        end
    end

    assign tx_underrun = underrun_pulse_q;
`endif

    always_comb begin
        phy_tx_en              = 1'b1;
        {phy_tx_dp, phy_tx_dn} = nrzi_line;
        case (state_q)
            ST_IDLE: begin
                phy_tx_en              = 1'b0;
                {phy_tx_dp, phy_tx_dn} = LS_J;
            end
            ST_EOP_SE0: {phy_tx_dp, phy_tx_dn} = LS_SE0;
            ST_EOP_J:   {phy_tx_dp, phy_tx_dn} = LS_J;
            default:    {phy_tx_dp, phy_tx_dn} = nrzi_line;
        endcase
    end

    assign in_ready = fetch & in_valid;
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_done  = done_q;

endmodule
